// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer:
// FSM state encoding and the frame-length helper.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Number of serial bits per word: data bits plus the optional parity bit.
    function automatic int frame_len(input int width, input int parity_en);
        return width + ((parity_en != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake in, serial bit stream out. The producer side uses master;
// the serializer uses slave.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, sout_last, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, sout_last, busy
    );
endinterface

// File: rtl/piso_bit_counter.sv
// Position counter within a serial frame; tc flags the final bit.
module piso_bit_counter #(
    parameter int FRAME = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         inc,
    output logic [$clog2(FRAME+1)-1:0]   count,
    output logic                         tc
);
    localparam int CW = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic [CW-1:0] count_reg;

    // clear wins over inc so a new frame always starts from bit 0
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign count = count_reg;
    assign tc    = (count_reg == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out stage: accepts a word on valid/ready and emits it
// one bit per clock, optionally followed by an even-parity bit.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic              clk,
    input  logic              rst,
    piso_serializer_if.slave  bus
);
    localparam int FRAME = frame_len(WIDTH, PARITY_EN);
    localparam int CW    = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    state_e              state_reg;
    state_e              state_next;
    logic [FRAME-1:0]    frame_reg;
    logic [FRAME-1:0]    frame_word;
    logic [(2**CW)-1:0]  frame_ext;
    logic [CW-1:0]       count;
    logic [CW-1:0]       bit_idx;
    logic                tc;
    logic                in_shift;
    logic                last_bit;
    logic                din_ready;
    logic                accept;

    assign in_shift  = (state_reg == ST_SHIFT);
    assign last_bit  = in_shift & tc;
    assign din_ready = (state_reg == ST_IDLE) | last_bit;
    assign accept    = bus.din_valid & din_ready;

    // Frame word is stored in transmit order: bit FRAME-1 goes out first.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_map
        localparam int SRC = (MSB_FIRST != 0) ? (WIDTH - 1 - gi) : gi;
        assign frame_word[FRAME-1-gi] = bus.din[SRC];
    end

    if (PARITY_EN != 0) begin : g_parity
        assign frame_word[0] = ^bus.din;
    end

    piso_bit_counter #(
        .FRAME (FRAME)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (accept | last_bit),
        .inc   (in_shift & ~tc),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tc && !accept) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Loaded on accept and cleared when the frame ends without a follow-on word.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_reg <= '0;
        end else if (accept) begin
            frame_reg <= frame_word;
        end else if (last_bit) begin
            frame_reg <= '0;
        end
    end

    // Bits are picked by counter position; zero-extension keeps the index width exact.
    assign frame_ext = {{((2**CW) - FRAME){1'b0}}, frame_reg};
    assign bit_idx   = LAST - count;

    assign bus.din_ready  = din_ready;
    assign bus.sout       = in_shift & frame_ext[bit_idx];
    assign bus.sout_valid = in_shift;
    assign bus.sout_last  = last_bit;
    assign bus.busy       = in_shift;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: four configurations (MSB first, LSB first,
// parity, one-bit words) checked against a queue of expected serial bits.
module tb_piso_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] din_v [4];
    logic       val_v [4];
    logic       so [4];
    logic       sv [4];
    logic       sl [4];
    logic       sb [4];
    logic       sr [4];

    piso_serializer_if #(.WIDTH(8)) if0 ();
    piso_serializer_if #(.WIDTH(8)) if1 ();
    piso_serializer_if #(.WIDTH(8)) if2 ();
    piso_serializer_if #(.WIDTH(1)) if3 ();

    assign if0.din = din_v[0];      assign if0.din_valid = val_v[0];
    assign if1.din = din_v[1];      assign if1.din_valid = val_v[1];
    assign if2.din = din_v[2];      assign if2.din_valid = val_v[2];
    assign if3.din = din_v[3][0:0]; assign if3.din_valid = val_v[3];

    assign so[0] = if0.sout; assign sv[0] = if0.sout_valid; assign sl[0] = if0.sout_last;
    assign sb[0] = if0.busy; assign sr[0] = if0.din_ready;
    assign so[1] = if1.sout; assign sv[1] = if1.sout_valid; assign sl[1] = if1.sout_last;
    assign sb[1] = if1.busy; assign sr[1] = if1.din_ready;
    assign so[2] = if2.sout; assign sv[2] = if2.sout_valid; assign sl[2] = if2.sout_last;
    assign sb[2] = if2.busy; assign sr[2] = if2.din_ready;
    assign so[3] = if3.sout; assign sv[3] = if3.sout_valid; assign sl[3] = if3.sout_last;
    assign sb[3] = if3.busy; assign sr[3] = if3.din_ready;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    piso_serializer #(.WIDTH(1), .MSB_FIRST(1), .PARITY_EN(0)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    typedef struct {
        int   id;
        logic b;
        logic last;
    } exp_t;

    typedef struct {
        int         id;
        logic [7:0] din;
        logic [8:0] bits;   // serial order: bits[n-1] first
        int         n;
    } vec_t;

    exp_t q [$];
    vec_t tbl [10];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle each DUT must match the head of the queue if it is that DUT's turn,
    // and be silent otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
                logic expv;
                expv = (q.size() > 0) && (q[0].id == k);
                chk($sformatf("sout_valid[%0d]", k), {31'd0, sv[k]}, {31'd0, expv});
                chk($sformatf("busy[%0d]", k), {31'd0, sb[k]}, {31'd0, expv});
                if (expv) begin
                    chk($sformatf("sout[%0d]", k), {31'd0, so[k]}, {31'd0, q[0].b});
                    chk($sformatf("sout_last[%0d]", k), {31'd0, sl[k]}, {31'd0, q[0].last});
                    void'(q.pop_front());
                end else begin
                    chk($sformatf("sout_idle[%0d]", k), {31'd0, so[k]}, 32'd0);
                    chk($sformatf("sout_last_idle[%0d]", k), {31'd0, sl[k]}, 32'd0);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) q.delete();
    end

    // Offer a word; exp_wait is the number of cycles din_ready must stay low first.
    task automatic send(input int id, input logic [7:0] w, input logic [8:0] bits,
                        input int n, input int exp_wait);
        int waited;
        exp_t e;
        @(negedge clk); #2;
        din_v[id] = w;
        val_v[id] = 1'b1;
        for (waited = 0; waited < 60; waited++) begin
            chk("din_ready", {31'd0, sr[id]}, {31'd0, (waited == exp_wait)});
            if (sr[id]) break;
            @(negedge clk); #2;
        end
        chk("accept_cycle", waited, exp_wait);
        if (sr[id]) begin
            for (int j = n - 1; j >= 0; j--) begin
                e.id = id; e.b = bits[j]; e.last = (j == 0);
                q.push_back(e);
            end
            $display("send dut=%0d din=%h bits=%0d waited=%0d", id, w, n, waited);
            @(posedge clk); #1;
        end
        val_v[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((q.size() != 0) && (t < 40)) begin
            @(negedge clk); #2;
            t++;
        end
        chk("drain_timeout", {31'd0, (t >= 40)}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            din_v[k] = 8'h00;
            val_v[k] = 1'b0;
        end
        tbl[0] = '{0, 8'hB5, 9'h0B5, 8};
        tbl[1] = '{1, 8'hB5, 9'h0AD, 8};
        tbl[2] = '{2, 8'hB5, 9'h16B, 9};
        tbl[3] = '{2, 8'h03, 9'h006, 9};
        tbl[4] = '{3, 8'h01, 9'h001, 1};
        tbl[5] = '{3, 8'h00, 9'h000, 1};
        tbl[6] = '{0, 8'h3C, 9'h03C, 8};
        tbl[7] = '{1, 8'h01, 9'h080, 8};
        tbl[8] = '{2, 8'hFF, 9'h1FE, 9};
        tbl[9] = '{0, 8'h00, 9'h000, 8};

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        for (int k = 0; k < 4; k++) chk("ready_in_reset", {31'd0, sr[k]}, 32'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].id, tbl[i].din, tbl[i].bits, tbl[i].n, 0);
            wait_idle();
        end

        // Back-to-back: second word must be taken in the first word's last bit.
        send(0, 8'hB5, 9'h0B5, 8, 0);
        send(0, 8'hA0, 9'h0A0, 8, 7);
        wait_idle();

        // One-bit words stream with sout_last on every bit.
        send(3, 8'h01, 9'h001, 1, 0);
        send(3, 8'h00, 9'h000, 1, 0);
        send(3, 8'h01, 9'h001, 1, 0);
        wait_idle();

        // Parity frames back-to-back.
        send(2, 8'hB5, 9'h16B, 9, 0);
        send(2, 8'h03, 9'h006, 9, 8);
        wait_idle();

        // Hold: 5A offered while B5 is mid-frame, din_ready low until B5's last bit.
        send(0, 8'hB5, 9'h0B5, 8, 0);
        send(0, 8'h5A, 9'h05A, 8, 7);
        wait_idle();

        // Reset during bit 3 of FF, then a fresh word.
        send(0, 8'hFF, 9'h0FF, 8, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("ready_after_rst", {31'd0, sr[0]}, 32'd1);
        chk("valid_after_rst", {31'd0, sv[0]}, 32'd0);
        chk("busy_after_rst", {31'd0, sb[0]}, 32'd0);
        chk("sout_after_rst", {31'd0, so[0]}, 32'd0);
        #1 rst = 1'b0;
        send(0, 8'h69, 9'h069, 8, 0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in / serial-out stage that feeds the serial bit input of the "101" Moore sequence detector (seq_moore). It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock. An even-parity bit can optionally be appended to each word. Back-to-back words stream with no idle gap, so the detector sees a continuous bit stream.

Parameters:
WIDTH, 8, data word width in bits (legal range >= 1)
MSB_FIRST, 1, 1 = shift the MSB out first; 0 = shift the LSB out first
PARITY_EN, 0, 1 = append one even-parity bit after the data bits (frame length = WIDTH + PARITY_EN)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
din  in  WIDTH  parallel word
din_valid  in  1  din holds a word to send
din_ready  out  1  block can accept a word this cycle
sout  out  1  serial bit; connects to the detector's x input
sout_valid  out  1  sout carries a frame bit this cycle
sout_last  out  1  current bit is the final bit of the frame
busy  out  1  a frame is in progress

Behaviour:
- Clock/reset: one clock (clk). Reset (rst) is synchronous and active-high, and overrides all other inputs.
- Reset values: state = IDLE, shift register = 0, bit counter = 0, sout = 0, sout_valid = 0, sout_last = 0, busy = 0. din_ready is 1 in the cycle after reset.
- FSM states: IDLE and SHIFT. Use a 1-bit state register. Any illegal value recovers to IDLE.
- Accept condition: a word is accepted at a rising edge when din_valid & din_ready are both high.
- din_ready: combinational. It equals (state == IDLE) | (state == SHIFT & sout_last).
- IDLE behaviour:
  - sout = 0 and sout_valid = 0, so the detector sees 0s.
  - On accept: load din, set counter = 0, go to SHIFT.
- SHIFT timing:
  - The first bit appears in the cycle after the accept edge (latency 1).
  - One bit is emitted per cycle, for FRAME = WIDTH + PARITY_EN cycles.
- Bit order: bits come from the shift register in MSB_FIRST order. The parity bit, when enabled, is emitted after all data bits.
- Parity: the even-parity bit is the XOR of all WIDTH bits of the accepted word, captured at accept time.
- sout_last: high exactly when counter == FRAME-1.
- End of frame: at the edge that ends the sout_last cycle:
  - If an accept occurs, load the new word. The next cycle carries its first bit, with no gap.
  - Otherwise go to IDLE.
- busy: equals (state == SHIFT).
- Outputs sout, sout_valid and sout_last are registered or decoded from registers only. There is no combinational path from din to sout.
- din_valid while din_ready = 0 is ignored. Upstream must hold din stable until accepted.
- Reset mid-frame: the frame is dropped and the block is in IDLE the next cycle. No partial bits are emitted after reset.
- WIDTH = 1 with PARITY_EN = 0: each frame is one bit, so sout_last = 1 on every valid bit.
- Counter width: $clog2(WIDTH + PARITY_EN + 1) bits. It never wraps within a frame.

Decomposition:
- Shared package: state encoding constants ST_IDLE = 1'b0 and ST_SHIFT = 1'b1, plus a FRAME-length helper function.
- One natural sub-module: piso_bit_counter.
  - Parameterised by FRAME.
  - Inputs: clear and inc.
  - Outputs: the count and a terminal-count flag, which drives sout_last.

Test Plan:
- Single word, MSB first: WIDTH = 8, MSB_FIRST = 1, PARITY_EN = 0, din = 8'hB5 accepted at edge k.
  - Required: sout = 1,0,1,1,0,1,0,1 in cycles k+1 to k+8, sout_valid high for exactly 8 cycles.
  - sout_last high only in cycle k+8; then IDLE with sout = 0.
- Back-to-back streaming: 8'hB5, then 8'hA0 held valid.
  - Required: the A0 accept occurs in B5's last cycle, giving 16 contiguous valid bits 10110101 10100000 with no gap.
  - The attached detector output y must rise 1 cycle after each "101" completes (overlapping occurrences count).
- LSB first: MSB_FIRST = 0, din = 8'hB5.
  - Required: sout = 1,0,1,0,1,1,0,1.
- Parity: PARITY_EN = 1, din = 8'hB5 (five 1s).
  - Required: 9-bit frame with 9th bit = 1 and sout_last on bit 9.
  - With din = 8'h03, the 9th bit = 0.
- Reset mid-frame: rst asserted during bit 3 of 8'hFF.
  - Required: the next cycle has sout_valid = 0, busy = 0, din_ready = 1, sout = 0.
  - A fresh word afterwards serialises correctly.
- Handshake hold: din_valid high with 8'h5A while busy, not in the last bit.
  - Required: din_ready = 0 and no load.
  - The word is accepted exactly at the sout_last cycle of the current frame.
